// File: rtl/int_div_sched_pkg.sv
// Shared constants and types for the integer-divide request scheduler.
package int_div_sched_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_NUM_REGS    = 32;
  localparam int DEFAULT_QUEUE_DEPTH = 4;

  typedef enum logic [1:0] {
    DISP_IDLE   = 2'd0,
    DISP_LAUNCH = 2'd1,
    DISP_RUN    = 2'd2
  } disp_state_t;

endpackage

// File: rtl/div_req_fifo.sv
// Request FIFO for the divide scheduler; depth must be a power of two so pointers wrap naturally.
module div_req_fifo
  import int_div_sched_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = DEFAULT_QUEUE_DEPTH,
  localparam int ptr_width = (depth > 1) ? $clog2(depth) : 1,
  localparam int count_width = $clog2(depth) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [width-1:0]       wdata,
  output logic [width-1:0]       rdata,
  output logic [count_width-1:0] count,
  output logic                   full,
  output logic                   empty
);

  logic [width-1:0]     mem [depth];
  logic [ptr_width-1:0] rd_ptr;
  logic [ptr_width-1:0] wr_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == count_width'(depth));
  assign empty   = (count == '0);
  // A full queue refuses pushes even when a pop happens on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/int_div_sched.sv
// Queues divide requests, tracks pending destination registers and hands
// entries one at a time to a multi-cycle divider.
module int_div_sched
  import int_div_sched_pkg::*;
#(
  parameter int data_width    = DEFAULT_DATA_WIDTH,
  parameter int num_regs      = DEFAULT_NUM_REGS,
  parameter int queue_depth   = DEFAULT_QUEUE_DEPTH,
  parameter int reg_sel_width = $clog2(num_regs)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enq_req,
  output logic                         enq_ready,
  input  logic [reg_sel_width-1:0]     enq_quot_sel,
  input  logic [reg_sel_width-1:0]     enq_mod_sel,
  input  logic [data_width-1:0]        enq_a,
  input  logic [data_width-1:0]        enq_b,
  output logic                         div_req,
  input  logic                         div_busy,
  output logic [reg_sel_width-1:0]     div_quot_sel,
  output logic [reg_sel_width-1:0]     div_mod_sel,
  output logic [data_width-1:0]        div_a,
  output logic [data_width-1:0]        div_b,
  input  logic                         div_wr_req,
  input  logic [reg_sel_width-1:0]     div_wr_sel,
  input  logic [reg_sel_width-1:0]     chk_sel0,
  input  logic [reg_sel_width-1:0]     chk_sel1,
  output logic                         chk_hazard0,
  output logic                         chk_hazard1,
  output logic [$clog2(queue_depth):0] queue_count,
  output logic                         idle
);

  typedef struct packed {
    logic [reg_sel_width-1:0] quot_sel;
    logic [reg_sel_width-1:0] mod_sel;
    logic [data_width-1:0]    a;
    logic [data_width-1:0]    b;
  } entry_t;

  logic [num_regs-1:0]      pending;
  logic [num_regs-1:0]      pending_next;
  logic [reg_sel_width-1:0] quot_sel_eff;
  logic                     waw_block;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     accept;
  logic                     push;
  logic                     launch;
  entry_t                   push_entry;
  entry_t                   head;
  disp_state_t              state;
  disp_state_t              state_next;

  // When both destinations match, only the remainder lands in the register.
  assign quot_sel_eff = (enq_quot_sel == enq_mod_sel) ? '0 : enq_quot_sel;
  assign waw_block    = ((enq_quot_sel != '0) && pending[enq_quot_sel]) ||
                        ((enq_mod_sel  != '0) && pending[enq_mod_sel]);
  assign enq_ready    = !fifo_full && !waw_block;
  assign accept       = enq_req && enq_ready;
  assign push         = accept && ((enq_quot_sel != '0) || (enq_mod_sel != '0));
  assign push_entry   = '{quot_sel: quot_sel_eff, mod_sel: enq_mod_sel, a: enq_a, b: enq_b};

  div_req_fifo #(
    .width ($bits(entry_t)),
    .depth (queue_depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (launch),
    .wdata (push_entry),
    .rdata (head),
    .count (queue_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // New reservations win over a snooped write; WAW blocking keeps them disjoint anyway.
  always_comb begin
    pending_next = pending;
    if (div_wr_req && (div_wr_sel != '0)) pending_next[div_wr_sel] = 1'b0;
    if (push) begin
      if (quot_sel_eff != '0) pending_next[quot_sel_eff] = 1'b1;
      if (enq_mod_sel  != '0) pending_next[enq_mod_sel]  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

  assign chk_hazard0 = (chk_sel0 != '0) && pending[chk_sel0];
  assign chk_hazard1 = (chk_sel1 != '0) && pending[chk_sel1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= DISP_IDLE;
      div_req      <= 1'b0;
      div_quot_sel <= '0;
      div_mod_sel  <= '0;
      div_a        <= '0;
      div_b        <= '0;
    end else begin
      state   <= state_next;
      div_req <= launch;
      if (launch) begin
        div_quot_sel <= head.quot_sel;
        div_mod_sel  <= head.mod_sel;
        div_a        <= head.a;
        div_b        <= head.b;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      DISP_IDLE:   if (!fifo_empty && !div_busy) state_next = DISP_LAUNCH;
      DISP_LAUNCH: state_next = DISP_RUN;
      DISP_RUN:    if (!div_busy) state_next = DISP_IDLE;
      default:     state_next = DISP_IDLE;
    endcase
  end

  always_comb begin
    launch = (state == DISP_IDLE) && !fifo_empty && !div_busy;
  end

  assign idle = (queue_count == '0) && (state == DISP_IDLE) && !div_busy;

endmodule

// File: doc/int_div_sched.md
INT_DIV_SCHED -- requirements
Module: int_div_sched

Interface
REQ-001 SHALL have parameters: data_width, 32, operand width; num_regs, 32, register count; queue_depth, 4, request queue entries (power of 2); reg_sel_width = $clog2(num_regs).
REQ-002 SHALL have ports: clk in 1, single clock; rst in 1, asynchronous active-high reset.
REQ-003 SHALL have ports: enq_req in 1, enqueue request; enq_ready out 1, request accepted this edge when high with enq_req.
REQ-004 SHALL have ports: enq_quot_sel in reg_sel_width, quotient destination (0 = none); enq_mod_sel in reg_sel_width, remainder destination (0 = none); enq_a and enq_b in data_width, dividend and divisor.
REQ-005 SHALL have ports: div_req out 1; div_busy in 1; div_quot_sel and div_mod_sel out reg_sel_width; div_a and div_b out data_width, all connected to the divider.
REQ-006 SHALL have ports: div_wr_req in 1 and div_wr_sel in reg_sel_width, snooped divider register-file writes.
REQ-007 SHALL have ports: chk_sel0 and chk_sel1 in reg_sel_width; chk_hazard0 and chk_hazard1 out 1, scoreboard lookups.
REQ-008 SHALL have ports: queue_count out $clog2(queue_depth)+1, occupancy; idle out 1.

Function
REQ-009 SHALL drive enq_ready = (queue_count < queue_depth) AND neither nonzero enq sel is pending in the scoreboard (WAW block); combinational.
REQ-010 SHALL, when enq_quot_sel == enq_mod_sel != 0, store quot_sel as 0, so only the remainder is written.
REQ-011 SHALL accept and silently discard a request with both sels 0: no queue entry, no divider use.
REQ-012 SHALL push accepted entries {quot_sel, mod_sel, a, b} into a FIFO and set pending bits for nonzero sels on the same edge.
REQ-013 SHALL clear pending[div_wr_sel] on every edge where div_wr_req=1 and div_wr_sel != 0.
REQ-014 SHALL drive chk_hazardN = pending[chk_selN], forced to 0 when chk_selN = 0; combinational.
REQ-015 SHALL implement dispatch FSM states IDLE, LAUNCH, RUN.
REQ-016 IDLE: if the queue is non-empty and div_busy=0, SHALL register div_req=1 with the head entry on div_*, pop the head, and go to LAUNCH.
REQ-017 LAUNCH: SHALL register div_req=0, hold div_* stable, and go to RUN.
REQ-018 RUN: SHALL hold div_quot_sel, div_mod_sel, div_a and div_b stable; on the first edge sampling div_busy=0, SHALL go to IDLE.
REQ-019 SHALL assert div_req for exactly one cycle per dispatched entry; it is never asserted outside IDLE to LAUNCH.
REQ-020 Latency: with the queue empty and the divider idle, an entry enqueued at edge E SHALL see div_req high in the cycle after E.
REQ-021 SHALL serve entries in strict FIFO order; a push and pop on the same edge SHALL leave count unchanged; a full queue SHALL accept nothing, with no bypass.
REQ-022 SHALL drive idle = (queue_count==0) AND (state==IDLE) AND !div_busy.

Reset
REQ-023 On rst SHALL asynchronously clear: queue empty (queue_count=0), all pending bits, state IDLE, div_req=0, div_quot_sel=0, div_mod_sel=0, div_a=0, div_b=0.
REQ-024 Reset mid-operation SHALL discard all queued and in-flight work; the divider shares rst.

Structure
REQ-025 SHALL place the dispatch state enum typedef in the shared constants package alongside existing constants.
REQ-026 SHALL implement the queue as sub-module div_req_fifo (parameterised width and depth, count output); scoreboard and FSM stay in int_div_sched.

Verification
REQ-027 Enqueue a=100, b=7, quot_sel=5, mod_sel=6 with an idle divider -> div_req pulses 1 cycle the next cycle; x5=14, x6=2 written; chk_hazard on 5 and 6 stays high until each write, then drops.
REQ-028 Enqueue 5 requests back-to-back (depth 4) while the divider is busy -> enq_ready low after 4 accepted; entries dispatched in order; 5th accepted after first pop.
REQ-029 Enqueue quot_sel=3, then a second request with mod_sel=3 -> second stalls (enq_ready=0) until x3 write is snooped.
REQ-030 Enqueue quot_sel=mod_sel=9, a=20, b=6 -> div_quot_sel=0, x9=2, single write, pending[9] cleared.
REQ-031 Enqueue both sels 0 -> queue_count stays 0, no div_req; chk_sel=0 always gives hazard 0.
REQ-032 Assert rst during RUN with 2 entries queued -> all outputs 0, queue_count=0, all hazards 0, idle=1 after divider reset.
